// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// regfile_wr_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares the register file's single write port between two writeback
//   requesters: A (ALU) and B (load/store unit). Arbitration is round-robin
//   with a valid/ready handshake on each side. The register file write port
//   is driven from flops, so an accepted write reaches the register file one
//   cycle after the handshake. A pending-write scoreboard (one bit per
//   architectural register) is set by the issue stage and cleared by
//   writeback so decode can stall on RAW hazards.
//
// Parameters:
//   XLEN  data width of the write value
//   RA_W  register-name width; the scoreboard has 2**RA_W bits
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   a_valid       requester A has a write
//   a_ready       A's write is accepted this cycle (combinational)
//   a_rd, a_data  A destination register and write value
//   b_valid       requester B has a write
//   b_ready       B's write is accepted this cycle (combinational)
//   b_rd, b_data  B destination register and write value
//   rsv_valid     issue stage reserves a destination register
//   rsv_rd        register being reserved
//   w_enable      register file write enable (registered)
//   w_reg_name    register file write address (registered)
//   w_reg_val     register file write data (registered)
//   pending       scoreboard, bit i set = register i has an outstanding write
//
// Optional feature (macro REGFILE_WR_ARBITER_STATS_EN):
//   conflict_cnt  saturating count of cycles where both requesters are valid
//   drop_cnt      saturating count of accepted transfers targeting register 0
//   With the macro undefined neither port nor counter exists.
// ============================================================================
module regfile_wr_arbiter #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [RA_W-1:0]      a_rd,
   input  logic [XLEN-1:0]      a_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [RA_W-1:0]      b_rd,
   input  logic [XLEN-1:0]      b_data,
   input  logic                 rsv_valid,
   input  logic [RA_W-1:0]      rsv_rd,
   output logic                 w_enable,
   output logic [RA_W-1:0]      w_reg_name,
   output logic [XLEN-1:0]      w_reg_val,
   output logic [(2**RA_W)-1:0] pending
`ifdef REGFILE_WR_ARBITER_STATS_EN
   ,
   output logic [15:0]          conflict_cnt,
   output logic [15:0]          drop_cnt
`endif
);

   localparam int NREG = 2**RA_W;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_e;

   grant_e            last_grant_q, last_grant_d;
   logic              w_enable_q,   w_enable_d;
   logic [RA_W-1:0]   w_reg_name_q, w_reg_name_d;
   logic [XLEN-1:0]   w_reg_val_q,  w_reg_val_d;
   logic [NREG-1:0]   pending_q,    pending_d;

   logic              grant_a;
   logic              grant_b;
   logic              accept;
   logic [RA_W-1:0]   acc_rd;
   logic [XLEN-1:0]   acc_data;
   logic              acc_writes;

   // Round-robin grant. A side that is alone always wins; on a tie the side
   // that did not win last time gets the port, which gives strict A,B,A,B
   // alternation under continuous contention. Nothing is granted while reset
   // is asserted so no requester believes its write was taken.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst) begin
         if (a_valid && b_valid) begin
            grant_a = (last_grant_q == GRANT_B);
            grant_b = (last_grant_q == GRANT_A);
         end else begin
            grant_a = a_valid;
            grant_b = b_valid;
         end
      end
   end

   // The handshake is simply the grant; valid is already folded into it.
   always_comb begin
      a_ready = grant_a;
      b_ready = grant_b;
   end

   // Select the winning transfer. A write to register 0 is still accepted
   // (the requester is released and fairness advances) but never reaches the
   // register file and never touches the scoreboard.
   always_comb begin
      accept     = grant_a | grant_b;
      acc_rd     = grant_a ? a_rd   : b_rd;
      acc_data   = grant_a ? a_data : b_data;
      acc_writes = accept && (acc_rd != '0);
   end

   // Next-state for the fairness pointer and the registered write port.
   // Address and data hold their previous values whenever no real write is
   // issued, so the register file sees a quiet bus between writes.
   always_comb begin
      last_grant_d = last_grant_q;
      w_enable_d   = 1'b0;
      w_reg_name_d = w_reg_name_q;
      w_reg_val_d  = w_reg_val_q;
      if (accept) begin
         last_grant_d = grant_a ? GRANT_A : GRANT_B;
      end
      if (acc_writes) begin
         w_enable_d   = 1'b1;
         w_reg_name_d = acc_rd;
         w_reg_val_d  = acc_data;
      end
   end

   // Scoreboard next-state. The retiring write clears its bit at the accept
   // edge (not when the register file is written) because the value is
   // already committed to the write pipeline. The reservation is applied
   // after the clear so a new reservation to the same register supersedes
   // the one retiring. Bit 0 is forced low as register 0 is never written.
   always_comb begin
      pending_d = pending_q;
      if (acc_writes) begin
         pending_d[acc_rd] = 1'b0;
      end
      if (rsv_valid && (rsv_rd != '0)) begin
         pending_d[rsv_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // State registers. Reset cancels any in-flight registered write, clears
   // the scoreboard and points the fairness pointer at B so A wins the
   // first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GRANT_B;
         w_enable_q   <= 1'b0;
         w_reg_name_q <= '0;
         w_reg_val_q  <= '0;
         pending_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         w_enable_q   <= w_enable_d;
         w_reg_name_q <= w_reg_name_d;
         w_reg_val_q  <= w_reg_val_d;
         pending_q    <= pending_d;
      end
   end

   // Register file write port and scoreboard come straight from flops.
   always_comb begin
      w_enable   = w_enable_q;
      w_reg_name = w_reg_name_q;
      w_reg_val  = w_reg_val_q;
      pending    = pending_q;
   end

`ifdef REGFILE_WR_ARBITER_STATS_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;
   logic [15:0] drop_cnt_q,     drop_cnt_d;

   // Statistics next-state. Conflicts count every contended cycle; drops
   // count accepted writes to register 0. Both saturate instead of wrapping
   // so a long run never reports a misleadingly small value.
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      drop_cnt_d     = drop_cnt_q;
      if (a_valid && b_valid && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
      if (accept && (acc_rd == '0) && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // Statistics registers; reset has priority so contention seen while rst
   // is high is never counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt_q <= '0;
         drop_cnt_q     <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
         drop_cnt_q     <= drop_cnt_d;
      end
   end

   // Expose the counters.
   always_comb begin
      conflict_cnt = conflict_cnt_q;
      drop_cnt     = drop_cnt_q;
   end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// tb_regfile_wr_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for regfile_wr_arbiter. Directed scenarios compare
// against constants; a randomized phase compares every cycle against a
// behavioural model of the arbiter kept in this file. Define
// REGFILE_WR_ARBITER_STATS_EN to also exercise the statistics counters.
// ============================================================================
module tb_regfile_wr_arbiter;

   localparam int XLEN = 32;
   localparam int RA_W = 5;
   localparam int NREG = 2**RA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              a_valid;
   logic              a_ready;
   logic [RA_W-1:0]   a_rd;
   logic [XLEN-1:0]   a_data;
   logic              b_valid;
   logic              b_ready;
   logic [RA_W-1:0]   b_rd;
   logic [XLEN-1:0]   b_data;
   logic              rsv_valid;
   logic [RA_W-1:0]   rsv_rd;
   logic              w_enable;
   logic [RA_W-1:0]   w_reg_name;
   logic [XLEN-1:0]   w_reg_val;
   logic [NREG-1:0]   pending;
`ifdef REGFILE_WR_ARBITER_STATS_EN
   logic [15:0]       conflict_cnt;
   logic [15:0]       drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural model state: who won the port last (1 = B), the write the
   // register file should see, and which registers are awaiting a write.
   logic              m_last_b;
   logic              m_wen;
   logic [RA_W-1:0]   m_wname;
   logic [XLEN-1:0]   m_wval;
   logic [NREG-1:0]   m_pend;

   regfile_wr_arbiter #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_rd       (a_rd),
      .a_data     (a_data),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_rd       (b_rd),
      .b_data     (b_data),
      .rsv_valid  (rsv_valid),
      .rsv_rd     (rsv_rd),
      .w_enable   (w_enable),
      .w_reg_name (w_reg_name),
      .w_reg_val  (w_reg_val),
      .pending    (pending)
`ifdef REGFILE_WR_ARBITER_STATS_EN
      ,
      .conflict_cnt (conflict_cnt),
      .drop_cnt     (drop_cnt)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Safety net so the run always ends even if something stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Which side should win this cycle, straight from the arbitration rules.
   task automatic model_grant(output logic ga, output logic gb);
      ga = 1'b0;
      gb = 1'b0;
      if (!rst) begin
         if (a_valid && b_valid) begin
            ga = m_last_b;
            gb = !m_last_b;
         end else begin
            ga = a_valid;
            gb = b_valid;
         end
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic            ga, gb;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] dat;
      model_grant(ga, gb);
      if (rst) begin
         m_last_b = 1'b1;
         m_wen    = 1'b0;
         m_wname  = '0;
         m_wval   = '0;
         m_pend   = '0;
      end else begin
         m_wen = 1'b0;
         if (ga || gb) begin
            rd       = ga ? a_rd   : b_rd;
            dat      = ga ? a_data : b_data;
            m_last_b = gb;
            if (rd != 0) begin
               m_wen      = 1'b1;
               m_wname    = rd;
               m_wval     = dat;
               m_pend[rd] = 1'b0;
            end
         end
         if (rsv_valid && rsv_rd != 0) m_pend[rsv_rd] = 1'b1;
      end
   endtask

   // One clock: update model, wait for the edge, then settle past it.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid   = 1'b0;
      a_rd      = '0;
      a_data    = '0;
      b_valid   = 1'b0;
      b_rd      = '0;
      b_data    = '0;
      rsv_valid = 1'b0;
      rsv_rd    = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      a_valid   = 1'b1;
      a_rd      = 5'd4;
      a_data    = 32'h1234;
      b_valid   = 1'b1;
      b_rd      = 5'd6;
      b_data    = 32'h5678;
      rsv_valid = 1'b1;
      rsv_rd    = 5'd9;
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_a_ready: got %b want 0", a_ready);
      end
      checks++;
      if (b_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_b_ready: got %b want 0", b_ready);
      end
      tick();
      tick();
      checks++;
      if (w_enable !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_w_enable: got %b want 0", w_enable);
      end
      checks++;
      if (w_reg_name !== 5'd0) begin
         errors++;
         $display("[TB] FAIL reset_w_reg_name: got %0d want 0", w_reg_name);
      end
      checks++;
      if (w_reg_val !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_w_reg_val: got %h want 0", w_reg_val);
      end
      checks++;
      if (pending !== '0) begin
         errors++;
         $display("[TB] FAIL reset_pending: got %h want 0", pending);
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single_a();
      a_valid = 1'b1;
      a_rd    = 5'd5;
      a_data  = 32'hDEADBEEF;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_a_ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
      end
      tick();
      idle_inputs();
      checks++;
      if (w_enable !== 1'b1 || w_reg_name !== 5'd5 || w_reg_val !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL single_a_write: got en=%b rd=%0d val=%h want en=1 rd=5 val=deadbeef",
                  w_enable, w_reg_name, w_reg_val);
      end
      tick();
      checks++;
      if (w_enable !== 1'b0 || w_reg_name !== 5'd5 || w_reg_val !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL single_a_after: got en=%b rd=%0d val=%h want en=0 rd=5 val=deadbeef",
                  w_enable, w_reg_name, w_reg_val);
      end
   endtask

   task automatic test_fairness();
      logic [RA_W-1:0] exp_name [4];
      int ai;
      int bi;
      logic exp_a;
      exp_name[0] = 5'd1;
      exp_name[1] = 5'd8;
      exp_name[2] = 5'd2;
      exp_name[3] = 5'd8;
      ai = 0;
      bi = 0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         a_valid = 1'b1;
         a_rd    = RA_W'(ai + 1);
         a_data  = 32'h10 + 32'(ai);
         b_valid = 1'b1;
         b_rd    = 5'd8;
         b_data  = 32'hB0 + 32'(bi);
         #1;
         exp_a = (k % 2 == 0);
         checks++;
         if (a_ready !== exp_a || b_ready !== !exp_a) begin
            errors++;
            $display("[TB] FAIL fair_grant[%0d]: got a=%b b=%b want a=%b b=%b",
                     k, a_ready, b_ready, exp_a, !exp_a);
         end
         tick();
         if (exp_a) ai++;
         else bi++;
         checks++;
         if (w_enable !== 1'b1 || w_reg_name !== exp_name[k]) begin
            errors++;
            $display("[TB] FAIL fair_write[%0d]: got en=%b rd=%0d want en=1 rd=%0d",
                     k, w_enable, w_reg_name, exp_name[k]);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_scoreboard();
      rsv_valid = 1'b1;
      rsv_rd    = 5'd7;
      tick();
      idle_inputs();
      tick();
      tick();
      checks++;
      if (pending[7] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sb_reserve: got pending[7]=%b want 1", pending[7]);
      end
      b_valid   = 1'b1;
      b_rd      = 5'd7;
      b_data    = 32'h77;
      rsv_valid = 1'b1;
      rsv_rd    = 5'd7;
      #1;
      checks++;
      if (b_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sb_b_ready: got %b want 1", b_ready);
      end
      tick();
      checks++;
      if (pending[7] !== 1'b1 || w_enable !== 1'b1 || w_reg_name !== 5'd7) begin
         errors++;
         $display("[TB] FAIL sb_set_wins: got pending[7]=%b en=%b rd=%0d want 1 1 7",
                  pending[7], w_enable, w_reg_name);
      end
      rsv_valid = 1'b0;
      b_data    = 32'h78;
      tick();
      checks++;
      if (pending[7] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sb_clear: got pending[7]=%b want 0", pending[7]);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_rd_zero();
      a_valid   = 1'b1;
      a_rd      = 5'd0;
      a_data    = 32'hFFFFFFFF;
      rsv_valid = 1'b1;
      rsv_rd    = 5'd0;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rd0_ready: got %b want 1", a_ready);
      end
      tick();
      checks++;
      if (w_enable !== 1'b0 || w_reg_name !== 5'd7 || w_reg_val !== 32'h78) begin
         errors++;
         $display("[TB] FAIL rd0_write: got en=%b rd=%0d val=%h want en=0 rd=7 val=78",
                  w_enable, w_reg_name, w_reg_val);
      end
      checks++;
      if (pending[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd0_pending: got pending[0]=%b want 0", pending[0]);
      end
      idle_inputs();
      tick();
      checks++;
      if (w_enable !== 1'b0 || pending[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd0_after: got en=%b pending[0]=%b want 0 0", w_enable, pending[0]);
      end
   endtask

   task automatic test_reset_mid();
      b_valid   = 1'b1;
      b_rd      = 5'd3;
      b_data    = 32'h33;
      rsv_valid = 1'b1;
      rsv_rd    = 5'd12;
      #1;
      checks++;
      if (b_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_b_ready: got %b want 1", b_ready);
      end
      tick();
      checks++;
      if (w_enable !== 1'b1 || pending[12] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_accepted: got en=%b pending[12]=%b want 1 1", w_enable, pending[12]);
      end
      rst       = 1'b1;
      a_valid   = 1'b1;
      a_rd      = 5'd9;
      rsv_valid = 1'b0;
      #1;
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_ready_in_rst: got a=%b b=%b want 0 0", a_ready, b_ready);
      end
      tick();
      checks++;
      if (w_enable !== 1'b0 || pending !== '0) begin
         errors++;
         $display("[TB] FAIL mid_cancel: got en=%b pending=%h want 0 0", w_enable, pending);
      end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      logic ga_exp, gb_exp;
      logic ga_obs, gb_obs;
      int a_wait;
      int b_wait;
      a_wait = 0;
      b_wait = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!a_valid && ($urandom_range(0, 3) != 0)) begin
            a_valid = 1'b1;
            a_rd    = RA_W'($urandom_range(0, NREG - 1));
            a_data  = $urandom;
         end
         if (!b_valid && ($urandom_range(0, 3) != 0)) begin
            b_valid = 1'b1;
            b_rd    = RA_W'($urandom_range(0, NREG - 1));
            b_data  = $urandom;
         end
         rsv_valid = ($urandom_range(0, 1) == 1);
         rsv_rd    = RA_W'($urandom_range(0, NREG - 1));
         #1;
         model_grant(ga_exp, gb_exp);
         ga_obs = a_ready;
         gb_obs = b_ready;
         checks++;
         if (ga_obs !== ga_exp || gb_obs !== gb_exp) begin
            errors++;
            $display("[TB] FAIL rand_grant[%0d]: got a=%b b=%b want a=%b b=%b",
                     c, ga_obs, gb_obs, ga_exp, gb_exp);
         end
         a_wait = (a_valid && !rst && ga_obs !== 1'b1) ? a_wait + 1 : 0;
         b_wait = (b_valid && !rst && gb_obs !== 1'b1) ? b_wait + 1 : 0;
         checks++;
         if (a_wait > 1 || b_wait > 1) begin
            errors++;
            $display("[TB] FAIL rand_starve[%0d]: got waits a=%0d b=%0d want <=1", c, a_wait, b_wait);
         end
         tick();
         checks++;
         if (w_enable !== m_wen || w_reg_name !== m_wname || w_reg_val !== m_wval) begin
            errors++;
            $display("[TB] FAIL rand_write[%0d]: got en=%b rd=%0d val=%h want en=%b rd=%0d val=%h",
                     c, w_enable, w_reg_name, w_reg_val, m_wen, m_wname, m_wval);
         end
         checks++;
         if (pending !== m_pend) begin
            errors++;
            $display("[TB] FAIL rand_pending[%0d]: got %h want %h", c, pending, m_pend);
         end
         if (rst) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            a_wait  = 0;
            b_wait  = 0;
         end else begin
            if (ga_obs === 1'b1) a_valid = 1'b0;
            if (gb_obs === 1'b1) b_valid = 1'b0;
         end
      end
      rst = 1'b0;
      idle_inputs();
      tick();
   endtask

`ifdef REGFILE_WR_ARBITER_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         a_valid = 1'b1;
         a_rd    = 5'd2;
         a_data  = 32'h2;
         b_valid = 1'b1;
         b_rd    = 5'd4;
         b_data  = 32'h4;
         tick();
      end
      idle_inputs();
      tick();
      checks++;
      if (conflict_cnt !== 16'd3 || drop_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL stats_conflict: got conflict=%0d drop=%0d want 3 0", conflict_cnt, drop_cnt);
      end
      a_valid = 1'b1;
      a_rd    = 5'd0;
      a_data  = 32'hFFFFFFFF;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (drop_cnt !== 16'd1 || conflict_cnt !== 16'd3) begin
         errors++;
         $display("[TB] FAIL stats_drop: got drop=%0d conflict=%0d want 1 3", drop_cnt, conflict_cnt);
      end
   endtask
`endif

   initial begin
      rst      = 1'b1;
      m_last_b = 1'b1;
      m_wen    = 1'b0;
      m_wname  = '0;
      m_wval   = '0;
      m_pend   = '0;
      idle_inputs();
      test_reset();
      test_single_a();
      test_fairness();
      test_scoreboard();
      test_rd_zero();
      test_reset_mid();
      test_random();
`ifdef REGFILE_WR_ARBITER_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU) and B (load/store unit).
- Arbitration is round-robin with a valid/ready handshake on each side.
- Drives the register file write port from registers, so writes are issued one cycle after acceptance.
- Keeps a pending-write scoreboard (one bit per register) that issue logic reserves and writeback retires, so decode can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of the write value.
- RA_W, 5, register-name width; number of scoreboard bits is 2**RA_W.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's write accepted this cycle (combinational).
- a_rd  in  RA_W  A destination register.
- a_data  in  XLEN  A write value.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's write accepted this cycle (combinational).
- b_rd  in  RA_W  B destination register.
- b_data  in  XLEN  B write value.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_rd  in  RA_W  register being reserved.
- w_enable  out  1  register file write enable (registered).
- w_reg_name  out  RA_W  register file write address (registered).
- w_reg_val  out  XLEN  register file write data (registered).
- pending  out  2**RA_W  scoreboard; bit i set means register i has an outstanding write.

Behaviour:
- Reset (rst=1 at a clk edge):
  - w_enable=0, w_reg_name=0, w_reg_val=0, pending=0.
  - last_grant=B, so A wins the first tie.
  - a_ready and b_ready are 0 while rst is high.
- Grant (combinational each cycle):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the side opposite last_grant.
  - Neither valid: no grant; last_grant unchanged.
- Handshake:
  - x_ready = grant_x. A transfer occurs when x_valid & x_ready.
  - A requester not granted must hold valid, rd and data stable. The arbiter never drops or reorders held requests.
- Accepted transfer:
  - Next edge: w_enable=1, w_reg_name=rd, w_reg_val=data.
  - last_grant is updated to the granted side.
  - Latency from accept to write is exactly 1 cycle. Throughput is 1 write per cycle.
- rd==0:
  - The transfer is accepted and last_grant updates.
  - Next cycle: w_enable=0; w_reg_name and w_reg_val hold their previous values.
- No accepted transfer: w_enable=0 next cycle; w_reg_name and w_reg_val hold their values.
- Scoreboard, per edge:
  - Set: bit rsv_rd is set if rsv_valid and rsv_rd!=0.
  - Clear: bit rd of the accepted transfer is cleared (if rd!=0). Clearing happens at the accept edge, not at the w_enable edge.
  - Same register set and cleared in the same cycle: set wins (a new reservation supersedes the retiring one).
  - Bit 0 is always 0.
  - Reserving an already-set bit leaves it set. The scoreboard keeps no count, so only one outstanding write per register is tracked.
- Fairness: with both requesters continuously valid, grants alternate A,B,A,B… Neither side waits more than 1 cycle.
- Reset mid-operation: an in-flight registered write is cancelled (w_enable=0 the cycle after reset). Pending bits are cleared. Requesters must re-present after reset deasserts.

Optional Feature:
- Macro: REGFILE_WR_ARBITER_STATS_EN.
- Defined:
  - Adds output conflict_cnt[15:0], reset to 0.
  - Increments on every cycle with a_valid & b_valid and rst=0, saturating at 16'hFFFF.
  - Adds output drop_cnt[15:0], reset to 0.
  - Increments on each accepted transfer with rd==0, saturating at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then A only (a_rd=5, a_data=32'hDEADBEEF) for 1 cycle -> a_ready=1 same cycle; next cycle w_enable=1, w_reg_name=5, w_reg_val=32'hDEADBEEF; following cycle w_enable=0.
- Both valid continuously for 4 cycles, from reset: A rd=1..4, data 32'h10..13; B rd=8 (B presents each next request after each accept) -> grant order A,B,A,B; w_reg_name sequence 1,8,2,8; each side waits at most 1 cycle.
- rsv_valid with rsv_rd=7, then two idle cycles -> pending[7]=1. Then B writes rd=7 while rsv_valid again with rsv_rd=7 -> pending[7] stays 1. A subsequent B write to rd=7 with no reservation -> pending[7]=0.
- A write rd=0 with data 32'hFFFFFFFF; rsv_rd=0 -> a_ready=1; w_enable stays 0; pending[0]=0 throughout.
- B write accepted (rd=3) with rst asserted on the following edge -> w_enable=0 after reset; pending=0; a_ready=b_ready=0 while rst=1.
- REGFILE_WR_ARBITER_STATS_EN defined:
  - 3 cycles with both valid -> conflict_cnt=3.
  - Preload conflict_cnt at 16'hFFFF -> stays at 16'hFFFF.
  - One rd=0 accept -> drop_cnt=1.
